// File: rtl/dcpu_operand_fetch.sv
// dcpu_operand_fetch
//   Multi-cycle DCPU-16 operand decode/fetch stage feeding dcpu_alu. Resolves
//   operand a then operand b of one instruction to 16-bit values, issuing
//   next-word and memory reads as needed, and reports the writeback
//   destination of a plus the updated PC/SP.
//
// Ports
//   clk, rst_n             rising-edge clock, synchronous active-low reset
//   start                  accept instr/pc_in/sp_in (ignored while busy)
//   instr                  [3:0] opcode, [9:4] a field, [15:10] b field
//   pc_in, sp_in           address after instr, current SP
//   o_in                   current O register (read live during decode)
//   reg_rsel/reg_rdata     register-file read port (combinational data)
//   mem_req/mem_addr       memory read request, address held while requesting
//   mem_rdata/mem_ack      read data, valid with the completing ack
//   busy                   high whenever not idle
//   valid                  one-cycle result strobe; results held until next start
//   opcode, a_val, b_val   ALU operands
//   a_dst/a_reg/a_addr     writeback target of operand a
//   pc_out, sp_out         PC after next-word fetches, SP after POP/PUSH
module dcpu_operand_fetch (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] instr,
  input  logic [15:0] pc_in,
  input  logic [15:0] sp_in,
  input  logic [15:0] o_in,
  output logic [2:0]  reg_rsel,
  input  logic [15:0] reg_rdata,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        valid,
  output logic [3:0]  opcode,
  output logic [15:0] a_val,
  output logic [15:0] b_val,
  output logic [2:0]  a_dst,
  output logic [2:0]  a_reg,
  output logic [15:0] a_addr,
  output logic [15:0] pc_out,
  output logic [15:0] sp_out
);

  typedef enum logic [2:0] {
    IDLE, A_DEC, A_NW, A_MEM, B_DEC, B_NW, B_MEM, DONE
  } state_e;

  typedef enum logic [2:0] {
    DST_REG  = 3'd0,
    DST_MEM  = 3'd1,
    DST_SP   = 3'd2,
    DST_PC   = 3'd3,
    DST_O    = 3'd4,
    DST_NONE = 3'd5
  } dst_e;

  typedef enum logic [1:0] {
    DEC_FIN, DEC_NW, DEC_MEM
  } dec_e;

  state_e      state_q, state_d;
  logic [3:0]  opcode_q, opcode_d;
  logic [5:0]  a_fld_q, a_fld_d;
  logic [5:0]  b_fld_q, b_fld_d;
  logic [15:0] pc_cur_q, pc_cur_d;
  logic [15:0] sp_cur_q, sp_cur_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] a_val_q, a_val_d;
  logic [15:0] b_val_q, b_val_d;
  dst_e        a_dst_q, a_dst_d;
  logic [2:0]  a_reg_q, a_reg_d;
  logic [15:0] a_addr_q, a_addr_d;

  logic        in_a;
  logic [5:0]  fld;

  dec_e        dec_kind;
  logic [15:0] dec_val;
  dst_e        dec_dst;
  logic [15:0] dec_addr;
  logic [15:0] dec_sp;
  logic [15:0] nw_addr;

  // Operand currently being processed and the Moore outputs.
  always_comb begin
    in_a     = (state_q == A_DEC) || (state_q == A_NW) || (state_q == A_MEM);
    fld      = in_a ? a_fld_q : b_fld_q;
    reg_rsel = ((state_q == IDLE) || (state_q == DONE)) ? '0 : fld[2:0];
    busy     = (state_q != IDLE);
    valid    = (state_q == DONE);
    mem_req  = (state_q == A_NW) || (state_q == B_NW) ||
               (state_q == A_MEM) || (state_q == B_MEM);
    mem_addr = '0;
    if ((state_q == A_NW) || (state_q == B_NW)) begin
      mem_addr = pc_cur_q;
    end else if ((state_q == A_MEM) || (state_q == B_MEM)) begin
      mem_addr = addr_q;
    end
  end

  // Field decode, shared by both operands.
  always_comb begin
    dec_kind = DEC_FIN;
    dec_val  = '0;
    dec_dst  = DST_NONE;
    dec_addr = '0;
    dec_sp   = sp_cur_q;
    if (fld[5]) begin
      dec_val = {11'd0, fld[4:0]};
    end else begin
      case (fld[4:3])
        2'b00: begin
          dec_val = reg_rdata;
          dec_dst = DST_REG;
        end
        2'b01: begin
          dec_kind = DEC_MEM;
          dec_addr = reg_rdata;
          dec_dst  = DST_MEM;
        end
        2'b10: begin
          dec_kind = DEC_NW;
          dec_dst  = DST_MEM;
        end
        default: begin
          case (fld[2:0])
            3'd0: begin                      // POP: read old sp, then increment
              dec_kind = DEC_MEM;
              dec_addr = sp_cur_q;
              dec_sp   = sp_cur_q + 16'd1;
              dec_dst  = DST_MEM;
            end
            3'd1: begin                      // PEEK
              dec_kind = DEC_MEM;
              dec_addr = sp_cur_q;
              dec_dst  = DST_MEM;
            end
            3'd2: begin                      // PUSH: decrement first, read new sp
              dec_kind = DEC_MEM;
              dec_addr = sp_cur_q - 16'd1;
              dec_sp   = sp_cur_q - 16'd1;
              dec_dst  = DST_MEM;
            end
            3'd3: begin
              dec_val = sp_cur_q;
              dec_dst = DST_SP;
            end
            3'd4: begin
              dec_val = pc_cur_q;
              dec_dst = DST_PC;
            end
            3'd5: begin
              dec_val = o_in;
              dec_dst = DST_O;
            end
            3'd6: begin
              dec_kind = DEC_NW;
              dec_dst  = DST_MEM;
            end
            default: begin
              dec_kind = DEC_NW;
              dec_dst  = DST_NONE;
            end
          endcase
        end
      endcase
    end
    // 0x1e addresses with the next word alone; 0x10-0x17 add the indexed register.
    nw_addr = fld[3] ? mem_rdata : (mem_rdata + reg_rdata);
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    a_fld_d  = a_fld_q;
    b_fld_d  = b_fld_q;
    pc_cur_d = pc_cur_q;
    sp_cur_d = sp_cur_q;
    addr_d   = addr_q;
    a_val_d  = a_val_q;
    b_val_d  = b_val_q;
    a_dst_d  = a_dst_q;
    a_reg_d  = a_reg_q;
    a_addr_d = a_addr_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          opcode_d = instr[3:0];
          a_fld_d  = instr[9:4];
          b_fld_d  = instr[15:10];
          pc_cur_d = pc_in;
          sp_cur_d = sp_in;
          if (instr[3:0] == 4'd0) begin
            a_val_d  = '0;
            a_dst_d  = DST_NONE;
            a_reg_d  = '0;
            a_addr_d = '0;
            state_d  = B_DEC;
          end else begin
            state_d  = A_DEC;
          end
        end
      end

      A_DEC, B_DEC: begin
        sp_cur_d = dec_sp;
        if (in_a) begin
          a_reg_d = fld[2:0];
        end
        case (dec_kind)
          DEC_FIN: begin
            if (in_a) begin
              a_val_d  = dec_val;
              a_dst_d  = dec_dst;
              a_addr_d = '0;
              state_d  = B_DEC;
            end else begin
              b_val_d  = dec_val;
              state_d  = DONE;
            end
          end
          DEC_MEM: begin
            addr_d = dec_addr;
            if (in_a) begin
              a_dst_d  = DST_MEM;
              a_addr_d = dec_addr;
              state_d  = A_MEM;
            end else begin
              state_d  = B_MEM;
            end
          end
          default: state_d = in_a ? A_NW : B_NW;
        endcase
      end

      A_NW, B_NW: begin
        if (mem_ack) begin
          pc_cur_d = pc_cur_q + 16'd1;
          if (fld == 6'h1f) begin
            if (in_a) begin
              a_val_d = mem_rdata;
              a_dst_d = DST_NONE;
              state_d = B_DEC;
            end else begin
              b_val_d = mem_rdata;
              state_d = DONE;
            end
          end else begin
            addr_d = nw_addr;
            if (in_a) begin
              a_dst_d  = DST_MEM;
              a_addr_d = nw_addr;
              state_d  = A_MEM;
            end else begin
              state_d  = B_MEM;
            end
          end
        end
      end

      A_MEM: begin
        if (mem_ack) begin
          a_val_d = mem_rdata;
          state_d = B_DEC;
        end
      end

      B_MEM: begin
        if (mem_ack) begin
          b_val_d = mem_rdata;
          state_d = DONE;
        end
      end

      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      opcode_q <= '0;
      a_fld_q  <= '0;
      b_fld_q  <= '0;
      pc_cur_q <= '0;
      sp_cur_q <= '0;
      addr_q   <= '0;
      a_val_q  <= '0;
      b_val_q  <= '0;
      a_dst_q  <= DST_REG;
      a_reg_q  <= '0;
      a_addr_q <= '0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      a_fld_q  <= a_fld_d;
      b_fld_q  <= b_fld_d;
      pc_cur_q <= pc_cur_d;
      sp_cur_q <= sp_cur_d;
      addr_q   <= addr_d;
      a_val_q  <= a_val_d;
      b_val_q  <= b_val_d;
      a_dst_q  <= a_dst_d;
      a_reg_q  <= a_reg_d;
      a_addr_q <= a_addr_d;
    end
  end

  assign opcode = opcode_q;
  assign a_val  = a_val_q;
  assign b_val  = b_val_q;
  assign a_dst  = a_dst_q;
  assign a_reg  = a_reg_q;
  assign a_addr = a_addr_q;
  assign pc_out = pc_cur_q;
  assign sp_out = sp_cur_q;

endmodule

// File: tb/tb_dcpu_operand_fetch.sv
// Testbench for dcpu_operand_fetch: a behavioural operand model fills a
// scoreboard at issue time; a monitor checks each valid strobe against it.
// A memory responder provides random or fixed ack delays.
module tb_dcpu_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] instr = '0;
  logic [15:0] pc_in = '0;
  logic [15:0] sp_in = '0;
  logic [15:0] o_in = '0;
  logic [2:0]  reg_rsel;
  logic [15:0] reg_rdata;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        busy;
  logic        valid;
  logic [3:0]  opcode;
  logic [15:0] a_val;
  logic [15:0] b_val;
  logic [2:0]  a_dst;
  logic [2:0]  a_reg;
  logic [15:0] a_addr;
  logic [15:0] pc_out;
  logic [15:0] sp_out;

  logic [15:0] regs [8];
  logic [15:0] mem  [65536];

  assign reg_rdata = regs[reg_rsel];

  always #5 clk = ~clk;

  dcpu_operand_fetch dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .instr     (instr),
    .pc_in     (pc_in),
    .sp_in     (sp_in),
    .o_in      (o_in),
    .reg_rsel  (reg_rsel),
    .reg_rdata (reg_rdata),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .busy      (busy),
    .valid     (valid),
    .opcode    (opcode),
    .a_val     (a_val),
    .b_val     (b_val),
    .a_dst     (a_dst),
    .a_reg     (a_reg),
    .a_addr    (a_addr),
    .pc_out    (pc_out),
    .sp_out    (sp_out)
  );

  typedef struct {
    logic [3:0]  opcode;
    logic [15:0] a_val;
    logic [15:0] b_val;
    logic [15:0] a_addr;
    logic [15:0] pc_out;
    logic [15:0] sp_out;
    logic [2:0]  a_dst;
    logic [2:0]  a_reg;
    int unsigned base_lat;
    int unsigned start_cyc;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned cyc = 0;
  int unsigned wait_total = 0;
  int          dly_mode = 0;
  bit          force_ack = 1'b0;

  bit          rsp_in_req = 1'b0;
  int          rsp_left = 0;
  logic [15:0] rsp_addr = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model for one operand field: value, destination, address,
  // and the effect on PC/SP and the number of memory accesses.
  task automatic eval_op(input logic [5:0] f, input logic [15:0] o,
                         inout logic [15:0] pc_c, inout logic [15:0] sp_c,
                         inout int unsigned acc,
                         output logic [15:0] val, output logic [2:0] dst,
                         output logic [15:0] addr);
    int k;
    logic [15:0] nw;
    k    = int'(f);
    addr = '0;
    val  = '0;
    dst  = 3'd5;
    if (k < 8) begin
      val = regs[k];
      dst = 3'd0;
    end else if (k < 16) begin
      addr = regs[k - 8];
      val  = mem[addr];
      dst  = 3'd1;
      acc += 1;
    end else if (k < 24) begin
      nw   = mem[pc_c];
      pc_c = pc_c + 16'd1;
      addr = nw + regs[k - 16];
      val  = mem[addr];
      dst  = 3'd1;
      acc += 2;
    end else if (k == 24) begin
      addr = sp_c;
      val  = mem[addr];
      sp_c = sp_c + 16'd1;
      dst  = 3'd1;
      acc += 1;
    end else if (k == 25) begin
      addr = sp_c;
      val  = mem[addr];
      dst  = 3'd1;
      acc += 1;
    end else if (k == 26) begin
      sp_c = sp_c - 16'd1;
      addr = sp_c;
      val  = mem[addr];
      dst  = 3'd1;
      acc += 1;
    end else if (k == 27) begin
      val = sp_c;
      dst = 3'd2;
    end else if (k == 28) begin
      val = pc_c;
      dst = 3'd3;
    end else if (k == 29) begin
      val = o;
      dst = 3'd4;
    end else if (k == 30) begin
      nw   = mem[pc_c];
      pc_c = pc_c + 16'd1;
      addr = nw;
      val  = mem[addr];
      dst  = 3'd1;
      acc += 2;
    end else if (k == 31) begin
      val  = mem[pc_c];
      pc_c = pc_c + 16'd1;
      dst  = 3'd5;
      acc += 1;
    end else begin
      val = 16'(k - 32);
      dst = 3'd5;
    end
  endtask

  task automatic issue(input logic [15:0] ins, input logic [15:0] pc,
                       input logic [15:0] sp, input logic [15:0] o,
                       input int dly, input bit spam);
    exp_t        e;
    logic [15:0] pc_c, sp_c, bv, ba;
    logic [2:0]  bd;
    int unsigned acc;
    int unsigned guard;
    acc  = 0;
    pc_c = pc;
    sp_c = sp;
    e.opcode = ins[3:0];
    e.a_reg  = ins[6:4];
    if (ins[3:0] == 4'd0) begin
      e.a_val    = '0;
      e.a_dst    = 3'd5;
      e.a_addr   = '0;
      e.base_lat = 2;
    end else begin
      eval_op(ins[9:4], o, pc_c, sp_c, acc, e.a_val, e.a_dst, e.a_addr);
      e.base_lat = 3;
    end
    eval_op(ins[15:10], o, pc_c, sp_c, acc, bv, bd, ba);
    e.b_val     = bv;
    e.pc_out    = pc_c;
    e.sp_out    = sp_c;
    e.base_lat += acc;
    dly_mode    = dly;

    @(negedge clk);
    start      = 1'b1;
    instr      = ins;
    pc_in      = pc;
    sp_in      = sp;
    o_in       = o;
    wait_total = 0;
    e.start_cyc = cyc;
    sb.push_back(e);
    @(negedge clk);
    start = spam;
    instr = 16'($urandom);
    pc_in = 16'($urandom);
    sp_in = 16'($urandom);
    guard = 0;
    while (sb.size() != 0 && guard < 300) begin
      @(negedge clk);
      guard++;
      if (spam) begin
        start = busy;
        instr = 16'($urandom);
        pc_in = 16'($urandom);
        sp_in = 16'($urandom);
      end
    end
    start = 1'b0;
    if (sb.size() != 0) begin
      check("timeout_waiting_valid", 32'(sb.size()), 32'd0);
      sb.delete();
    end
  endtask

  // Memory responder: ack after 0..3 (random) or a fixed number of wait cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (!rsp_in_req) begin
          rsp_in_req = 1'b1;
          rsp_left   = (dly_mode < 0) ? int'($urandom_range(0, 3)) : dly_mode;
          rsp_addr   = mem_addr;
        end else begin
          check("mem_addr_stable", 32'(mem_addr), 32'(rsp_addr));
        end
        if (rsp_left == 0) begin
          mem_ack    = 1'b1;
          mem_rdata  = mem[mem_addr];
          rsp_in_req = 1'b0;
        end else begin
          mem_ack    = 1'b0;
          mem_rdata  = 16'($urandom);
          rsp_left--;
          wait_total++;
        end
      end else begin
        rsp_in_req = 1'b0;
        mem_ack    = force_ack;
        mem_rdata  = 16'($urandom);
      end
    end
  end

  // Monitor: compare every valid strobe with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && valid) begin
        if (sb.size() == 0) begin
          check("unexpected_valid", 32'(valid), 32'd0);
        end else begin
          e = sb.pop_front();
          check("opcode", 32'(opcode), 32'(e.opcode));
          check("a_val",  32'(a_val),  32'(e.a_val));
          check("b_val",  32'(b_val),  32'(e.b_val));
          check("a_dst",  32'(a_dst),  32'(e.a_dst));
          if (e.a_dst == 3'd0) check("a_reg",  32'(a_reg),  32'(e.a_reg));
          if (e.a_dst == 3'd1) check("a_addr", 32'(a_addr), 32'(e.a_addr));
          check("pc_out", 32'(pc_out), 32'(e.pc_out));
          check("sp_out", 32'(sp_out), 32'(e.sp_out));
          check("latency", cyc - e.start_cyc, e.base_lat + wait_total);
          @(negedge clk);
          check("valid_pulse", 32'(valid), 32'd0);
          check("a_val_hold",  32'(a_val),  32'(e.a_val));
          check("b_val_hold",  32'(b_val),  32'(e.b_val));
          check("pc_out_hold", 32'(pc_out), 32'(e.pc_out));
        end
      end
    end
  end

  initial begin
    int unsigned guard;
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);

    repeat (3) @(negedge clk);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_valid",   32'(valid),   32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_pc_out",  32'(pc_out),  32'd0);
    check("rst_sp_out",  32'(sp_out),  32'd0);
    check("rst_a_dst",   32'(a_dst),   32'd0);
    check("rst_a_val",   32'(a_val),   32'd0);
    check("rst_b_val",   32'(b_val),   32'd0);
    check("rst_opcode",  32'(opcode),  32'd0);
    check("rst_reg_rsel",32'(reg_rsel),32'd0);
    rst_n = 1'b1;

    // register a=A, literal b=0x1f
    regs[0] = 16'h1234;
    issue(16'hFC01, 16'h0100, 16'h8000, 16'h0000, 0, 1'b0);
    // next-word address a, next-word literal b
    mem[16'h0010] = 16'h1000;
    mem[16'h1000] = 16'hBEEF;
    mem[16'h0011] = 16'h0042;
    issue(16'h7DE1, 16'h0010, 16'h8000, 16'h0000, -1, 1'b0);
    // indexed with address wrap, 3-cycle ack delay
    regs[0] = 16'h0002;
    mem[16'h0040] = 16'hFFFF;
    issue(16'h8101, 16'h0040, 16'h8000, 16'h0000, 3, 1'b0);
    // PUSH then POP at sp 0
    issue(16'h61A1, 16'h0200, 16'h0000, 16'h0000, -1, 1'b0);
    // non-basic, b = PC
    issue(16'h7010, 16'h0020, 16'h1000, 16'h0000, -1, 1'b0);
    // indexed on both operands, no waits
    issue(16'h4112, 16'h0300, 16'h1000, 16'h0000, 0, 1'b0);
    // PC wrap through next-word fetches
    issue(16'h79F3, 16'hFFFF, 16'h1000, 16'h0000, 0, 1'b0);
    // POP at 0xFFFF, then b = SP
    issue(16'h6D84, 16'h0400, 16'hFFFF, 16'h5A5A, -1, 1'b0);
    // a = O, b = SP
    issue(16'h6DD5, 16'h0500, 16'h2222, 16'hC3C3, -1, 1'b0);
    // start held high while busy must be ignored
    issue(16'h4112, 16'h0600, 16'h3000, 16'h0000, 2, 1'b1);

    // abort during A_MEM
    dly_mode = 20;
    @(negedge clk);
    start = 1'b1;
    instr = 16'h0081;
    pc_in = 16'h0700;
    sp_in = 16'h4000;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (!mem_req && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check("abort_mem_req_seen", 32'(mem_req), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_mem_req", 32'(mem_req), 32'd0);
    check("abort_busy",    32'(busy),    32'd0);
    check("abort_valid",   32'(valid),   32'd0);
    check("abort_pc_out",  32'(pc_out),  32'd0);
    check("abort_sp_out",  32'(sp_out),  32'd0);
    check("abort_a_dst",   32'(a_dst),   32'd0);
    rst_n = 1'b1;
    force_ack = 1'b1;
    repeat (2) @(negedge clk);
    force_ack = 1'b0;
    @(negedge clk);
    check("stray_ack_busy",  32'(busy),  32'd0);
    check("stray_ack_valid", 32'(valid), 32'd0);

    for (int i = 0; i < 60; i++) begin
      for (int r = 0; r < 8; r++) regs[r] = 16'($urandom);
      issue(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), -1, (i % 7) == 3);
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
